// File: rtl/mux_onehot_cfg_chain.sv
// One-hot routing mux with its own serial configuration chain, staged commit and
// multi-hot detection. The cell chains head-to-tail with other configuration cells.
module mux_onehot_cfg_chain #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned REG_OUT    = 0
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  ccff_head,
  input  logic                  ccff_shift_en,
  output logic                  ccff_tail,
  input  logic                  cfg_commit,
  input  logic [NUM_INPUTS-1:0] in,
  output logic                  out,
  output logic [NUM_INPUTS-1:0] mem,
  output logic [NUM_INPUTS-1:0] mem_inv,
  output logic                  cfg_ready,
  output logic                  onehot_err
);

  localparam int unsigned CntW = $clog2(NUM_INPUTS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(NUM_INPUTS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [NUM_INPUTS-1:0] WordOne = NUM_INPUTS'(1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} fill_e;

  logic [NUM_INPUTS-1:0] sr_q, sr_d;
  logic [NUM_INPUTS-1:0] mem_q, mem_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  commit_ok;
  logic                  multi_hot;
  logic                  sel_val;
  fill_e                 fill;

  always_comb begin
    if (cnt_q == '0) begin
      fill = StEmpty;
    end else if (cnt_q == CntFull) begin
      fill = StFull;
    end else begin
      fill = StFilling;
    end
  end

  assign commit_ok = cfg_commit && (fill == StFull);
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = |(sr_q & (sr_q - WordOne));

  always_comb begin
    sr_d  = sr_q;
    mem_d = mem_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (ccff_shift_en) begin
      sr_d = {sr_q[NUM_INPUTS-2:0], ccff_head};
    end
    if (commit_ok) begin
      mem_d = sr_q;
      err_d = multi_hot;
      cnt_d = ccff_shift_en ? CntOne : '0;
    end else if (ccff_shift_en && (fill != StFull)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // A corrupted select must never drive the routing track.
  assign sel_val = err_q ? 1'b0 : |(in & mem_q);

  if (REG_OUT != 0) begin : g_reg_out
    logic out_q;
    always_ff @(posedge prog_clk) begin
      if (pReset) begin
        out_q <= 1'b0;
      end else begin
        out_q <= sel_val;
      end
    end
    assign out = out_q;
  end else begin : g_comb_out
    assign out = sel_val;
  end

  assign ccff_tail  = sr_q[NUM_INPUTS-1];
  assign mem        = mem_q;
  assign mem_inv    = ~mem_q;
  assign cfg_ready  = (fill == StFull);
  assign onehot_err = err_q;

endmodule

// File: tb/tb_mux_onehot_cfg_chain.sv
// Bench for mux_onehot_cfg_chain: two chained combinational-output cells plus a
// registered-output cell, all checked against a bit-history reference model.
module tb_mux_onehot_cfg_chain;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic head = 1'b0;
  logic shift = 1'b0;
  logic commit = 1'b0;
  logic [N-1:0] din = '0;

  logic tail_a, tail_b, tail_r;
  logic out_a, out_b, out_r;
  logic ready_a, ready_b, ready_r;
  logic err_a, err_b, err_r;
  logic [N-1:0] mem_a, mem_b, mem_r;
  logic [N-1:0] inv_a, inv_b, inv_r;

  int checks = 0;
  int errors = 0;

  // Reference model: history of shifted bits, newest first.
  bit hist[$];
  int cnt_m = 0;
  logic [N-1:0] mem_am = '0, mem_bm = '0;
  logic err_am = 1'b0, err_bm = 1'b0, outr_m = 1'b0;

  always #5 clk = ~clk;

  mux_onehot_cfg_chain #(.NUM_INPUTS(N), .REG_OUT(0)) dut_a (
    .prog_clk(clk), .pReset(rst), .ccff_head(head), .ccff_shift_en(shift),
    .ccff_tail(tail_a), .cfg_commit(commit), .in(din), .out(out_a), .mem(mem_a),
    .mem_inv(inv_a), .cfg_ready(ready_a), .onehot_err(err_a)
  );

  mux_onehot_cfg_chain #(.NUM_INPUTS(N), .REG_OUT(0)) dut_b (
    .prog_clk(clk), .pReset(rst), .ccff_head(tail_a), .ccff_shift_en(shift),
    .ccff_tail(tail_b), .cfg_commit(commit), .in(din), .out(out_b), .mem(mem_b),
    .mem_inv(inv_b), .cfg_ready(ready_b), .onehot_err(err_b)
  );

  mux_onehot_cfg_chain #(.NUM_INPUTS(N), .REG_OUT(1)) dut_r (
    .prog_clk(clk), .pReset(rst), .ccff_head(head), .ccff_shift_en(shift),
    .ccff_tail(tail_r), .cfg_commit(commit), .in(din), .out(out_r), .mem(mem_r),
    .mem_inv(inv_r), .cfg_ready(ready_r), .onehot_err(err_r)
  );

  // Bit i of a cell's register holds the bit shifted in (off + i) shifts ago.
  function automatic logic [N-1:0] sr_word(input int off);
    logic [N-1:0] w;
    for (int i = 0; i < N; i++) begin
      w[i] = (off + i < hist.size()) ? hist[off+i] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic exp_out(input logic [N-1:0] m, input logic e, input logic [N-1:0] d);
    return e ? 1'b0 : ((d & m) != '0);
  endfunction

  task automatic tick(input logic h, input logic s, input logic c, input logic r);
    head = h; shift = s; commit = c; rst = r;
    @(posedge clk);
    if (r) begin
      hist.delete();
      cnt_m = 0; mem_am = '0; mem_bm = '0; err_am = 1'b0; err_bm = 1'b0; outr_m = 1'b0;
    end else begin
      outr_m = exp_out(mem_am, err_am, din);
      if (c && cnt_m == N) begin
        mem_am = sr_word(0);
        mem_bm = sr_word(N);
        err_am = $countones(mem_am) > 1;
        err_bm = $countones(mem_bm) > 1;
        cnt_m = s ? 1 : 0;
      end else if (s && cnt_m < N) begin
        cnt_m++;
      end
      if (s) begin
        hist.push_front(h);
        if (hist.size() > 2 * N) void'(hist.pop_back());
      end
    end
    #1;
    head = 1'b0; shift = 1'b0; commit = 1'b0; rst = 1'b0;
  endtask

  // Shift a word so that it ends up as the cell's register contents (MSB first).
  task automatic shift_word(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) tick(w[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    din = '1;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks += 7;
    if (mem_a !== 8'h00) begin errors++; $display("FAIL reset_mem got %h want 00", mem_a); end
    if (inv_a !== 8'hFF) begin errors++; $display("FAIL reset_inv got %h want FF", inv_a); end
    if (out_a !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out_a); end
    if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_a); end
    if (tail_a !== 1'b0) begin errors++; $display("FAIL reset_tail got %b want 0", tail_a); end
    if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_a); end
    if (out_r !== 1'b0) begin errors++; $display("FAIL reset_out_r got %b want 0", out_r); end
  endtask

  task automatic test_select;
    logic [N-1:0] seq;
    logic v;
    seq = 8'b0010_0000;  // seq[j] is the j-th bit shifted in
    for (int j = 0; j < N; j++) begin
      tick(seq[j], 1'b1, 1'b0, 1'b0);
      checks++;
      if (ready_a !== (j == N - 1)) begin
        errors++; $display("FAIL sel_ready shift %0d got %b want %b", j, ready_a, j == N - 1);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 3;
    if (mem_a !== 8'b0000_0100) begin errors++; $display("FAIL sel_mem got %b want 00000100", mem_a); end
    if (inv_a !== 8'b1111_1011) begin errors++; $display("FAIL sel_inv got %b want 11111011", inv_a); end
    if (ready_a !== 1'b0) begin errors++; $display("FAIL sel_ready_fall got %b want 0", ready_a); end
    for (int k = 0; k < 3; k++) begin
      v = (k == 1);
      din = 8'hFB | {5'b0, v, 2'b0};
      #1;
      checks++;
      if (out_a !== v) begin errors++; $display("FAIL sel_toggle got %b want %b", out_a, v); end
    end
    for (int k = 0; k < 8; k++) begin
      din = N'($urandom);
      #1;
      checks++;
      if (out_a !== exp_out(mem_am, err_am, din)) begin
        errors++; $display("FAIL sel_rand in=%h got %b want %b", din, out_a, exp_out(mem_am, err_am, din));
      end
    end
  endtask

  task automatic test_early_commit;
    for (int j = 0; j < 5; j++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (mem_a !== 8'h04) begin errors++; $display("FAIL early_mem got %h want 04", mem_a); end
    if (ready_a !== 1'b0) begin errors++; $display("FAIL early_ready got %b want 0", ready_a); end
    for (int j = 0; j < 3; j++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      checks++;
      if (ready_a !== (j == 2)) begin
        errors++; $display("FAIL early_fill shift %0d got %b want %b", j, ready_a, j == 2);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (mem_a !== mem_am) begin errors++; $display("FAIL early_commit got %h want %h", mem_a, mem_am); end
  endtask

  task automatic test_two_hot;
    logic [N-1:0] w;
    shift_word(8'b0010_0010);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    din = 8'hFF;
    #1;
    checks += 2;
    if (err_a !== 1'b1) begin errors++; $display("FAIL twohot_err got %b want 1", err_a); end
    if (out_a !== 1'b0) begin errors++; $display("FAIL twohot_out got %b want 0", out_a); end
    w = N'(1) << $urandom_range(0, N - 1);
    shift_word(w);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 3;
    if (err_a !== 1'b0) begin errors++; $display("FAIL onehot_err got %b want 0", err_a); end
    if (mem_a !== w) begin errors++; $display("FAIL onehot_mem got %h want %h", mem_a, w); end
    if (out_a !== 1'b1) begin errors++; $display("FAIL onehot_out got %b want 1", out_a); end
  endtask

  task automatic test_chain;
    logic [2*N-1:0] bits;
    logic [N-1:0] wa, wb;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    bits = (2 * N)'($urandom);
    for (int j = 0; j < 2 * N; j++) tick(bits[j], 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) begin
      wb[N-1-j] = bits[j];
      wa[N-1-j] = bits[N+j];
    end
    checks += 4;
    if (mem_a !== wa) begin errors++; $display("FAIL chain_mem_a got %h want %h", mem_a, wa); end
    if (mem_b !== wb) begin errors++; $display("FAIL chain_mem_b got %h want %h", mem_b, wb); end
    if (err_b !== ($countones(wb) > 1)) begin errors++; $display("FAIL chain_err_b got %b", err_b); end
    if (tail_b !== wb[N-1]) begin errors++; $display("FAIL chain_tail_b got %b want %b", tail_b, wb[N-1]); end
  endtask

  task automatic test_reg_out;
    logic prev;
    shift_word(N'(1) << $urandom_range(0, N - 1));
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      din = N'($urandom);
      prev = exp_out(mem_am, err_am, din);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      din = ~din;  // out_r must not follow the new input until the next edge
      #1;
      checks++;
      if (out_r !== prev || out_r !== outr_m) begin
        errors++; $display("FAIL regout cycle %0d got %b want %b", k, out_r, prev);
      end
    end
  endtask

  task automatic test_commit_shift;
    logic [N-1:0] w1;
    w1 = N'($urandom);
    shift_word(w1);
    tick(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    checks += 2;
    if (mem_a !== w1) begin errors++; $display("FAIL cs_mem got %h want %h", mem_a, w1); end
    if (ready_a !== 1'b0) begin errors++; $display("FAIL cs_ready got %b want 0", ready_a); end
    for (int j = 0; j < N - 1; j++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      checks++;
      if (ready_a !== (j == N - 2)) begin
        errors++; $display("FAIL cs_refill shift %0d got %b want %b", j, ready_a, j == N - 2);
      end
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks += 3;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL rm_ready got %b want 0", ready_a); end
    if (tail_a !== 1'b0) begin errors++; $display("FAIL rm_tail got %b want 0", tail_a); end
    if (mem_a !== '0) begin errors++; $display("FAIL rm_mem got %h want 00", mem_a); end
    for (int j = 0; j < 7; j++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (tail_a !== 1'b0) begin errors++; $display("FAIL rm_tail shift %0d got %b want 0", j, tail_a); end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (mem_a !== '0) begin errors++; $display("FAIL rm_refused got %h want 00", mem_a); end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (mem_a !== 8'hFF) begin errors++; $display("FAIL rm_commit got %h want FF", mem_a); end
    if (err_a !== 1'b1) begin errors++; $display("FAIL rm_err got %b want 1", err_a); end
  endtask

  task automatic test_mirror;
    logic [N-1:0] sa;
    din = N'($urandom);
    #1;
    sa = sr_word(0);
    checks += 9;
    if (ready_b !== (cnt_m == N)) begin errors++; $display("FAIL mir_ready_b got %b", ready_b); end
    if (err_b !== err_bm) begin errors++; $display("FAIL mir_err_b got %b want %b", err_b, err_bm); end
    if (inv_b !== ~mem_bm) begin errors++; $display("FAIL mir_inv_b got %h want %h", inv_b, ~mem_bm); end
    if (out_b !== exp_out(mem_bm, err_bm, din)) begin errors++; $display("FAIL mir_out_b got %b", out_b); end
    if (mem_r !== mem_am) begin errors++; $display("FAIL mir_mem_r got %h want %h", mem_r, mem_am); end
    if (inv_r !== ~mem_am) begin errors++; $display("FAIL mir_inv_r got %h want %h", inv_r, ~mem_am); end
    if (ready_r !== (cnt_m == N)) begin errors++; $display("FAIL mir_ready_r got %b", ready_r); end
    if (err_r !== err_am) begin errors++; $display("FAIL mir_err_r got %b want %b", err_r, err_am); end
    if (tail_r !== sa[N-1]) begin errors++; $display("FAIL mir_tail_r got %b want %b", tail_r, sa[N-1]); end
  endtask

  initial begin
    #2;
    test_reset;
    test_select;
    test_early_commit;
    test_two_hot;
    test_chain;
    test_reg_out;
    test_commit_shift;
    test_mirror;
    test_reset_mid;
    test_mirror;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_onehot_cfg_chain.md
# mux_onehot_cfg_chain

Parametrised one-hot routing multiplexer with its own serial configuration memory. It generalises the fixed-size transmission-gate basis muxes to any input count. It adds a scan-chain shift register, a staged commit into active select memory, and one-hot integrity checking. It sits in routing and LUT-output paths, chained head-to-tail with other configuration cells.

## Interface
- NUM_INPUTS, 8: number of data inputs and select bits (2..64).
- REG_OUT, 0: 0 = combinational out; 1 = out registered on prog_clk.

- prog_clk  in  1  sole clock; all state updates on rising edge.
- pReset  in  1  reset, synchronous and active-high.
- ccff_head  in  1  serial configuration data in.
- ccff_shift_en  in  1  shift one bit this cycle.
- ccff_tail  out  1  serial data out (= sr[NUM_INPUTS-1]) to next cell's ccff_head.
- cfg_commit  in  1  request transfer of shift register into active memory.
- in  in  NUM_INPUTS  data inputs, bit 0 first.
- out  out  1  selected data.
- mem  out  NUM_INPUTS  active select bits.
- mem_inv  out  NUM_INPUTS  always ~mem.
- cfg_ready  out  1  high when shift count == NUM_INPUTS.
- onehot_err  out  1  committed select has more than one bit set.

## Operation
- Shift register sr[0:NUM_INPUTS-1]. On ccff_shift_en: sr[0] <= ccff_head and sr[i] <= sr[i-1]. The first bit shifted lands in sr[NUM_INPUTS-1] after NUM_INPUTS shifts.
- Counter cnt, width clog2(NUM_INPUTS+1), increments per shift and saturates at NUM_INPUTS. cfg_ready = (cnt == NUM_INPUTS).
- Fill states, derived from cnt:
  - EMPTY: cnt = 0.
  - FILLING: 0 < cnt < N.
  - FULL: cnt = N.
  - Shifting while FULL keeps FULL; sr still shifts.
- Commit accepted only when cfg_commit && cfg_ready:
  - mem <= sr (pre-shift value when ccff_shift_en is high in the same cycle).
  - onehot_err <= popcount(sr) > 1.
  - cnt <= ccff_shift_en ? 1 : 0.
- cfg_commit while not FULL is ignored: mem, onehot_err and cnt are unchanged, and the shift proceeds normally.
- Datapath: sel = |(in & mem).
  - out = onehot_err ? 0 : sel.
  - All-zero mem is legal (unused mux): out = 0 and onehot_err = 0.
- REG_OUT=1: out register loads the above value every cycle.
- Reset values:
  - sr = 0, cnt = 0, mem = 0, mem_inv = all ones.
  - ccff_tail = 0, cfg_ready = 0, onehot_err = 0, out = 0.
- Reset has priority over shift and commit in the same cycle. A reset during FILLING discards partial configuration.

## Timing
- Shift: ccff_tail reflects the new sr[N-1] one cycle after the shift_en edge. The chain delay per cell is NUM_INPUTS shifts.
- Commit: mem, mem_inv and onehot_err update at the commit edge and are visible the following cycle.
- REG_OUT=0: out follows in and mem combinationally, with zero latency.
- REG_OUT=1: out has 1 cycle latency from in or mem.
- cfg_ready rises the cycle after the NUM_INPUTS-th shift edge. It falls the cycle after an accepted commit, or stays high if a shift accompanies the commit and NUM_INPUTS == 1; this case is excluded by the NUM_INPUTS >= 2 range.
- No combinational path from ccff_head, ccff_shift_en or cfg_commit to any output.

## Test plan
1. Reset, N=8: hold pReset 1 cycle. Then mem = 8'h00, mem_inv = 8'hFF, out = 0, cfg_ready = 0, ccff_tail = 0.
2. Select in[2], N=8, REG_OUT=0:
   - Shift 0,0,0,0,0,1,0,0 (first bit first); cfg_ready = 1 after the 8th edge.
   - Pulse cfg_commit: next cycle mem = 8'b0000_0100.
   - Toggle in[2] 0→1→0 with other inputs = 1: out follows in[2] in the same cycle.
3. Early commit: 5 shifts, then cfg_commit. mem and cnt (= 5) are unchanged. 3 more shifts give cfg_ready = 1.
4. Two-hot: load mem bits 1 and 5 set, then commit. onehot_err = 1 and out = 0 for in = 8'hFF. Recommit a one-hot word: onehot_err returns to 0.
5. Chain and REG_OUT:
   - Two N=8 instances tail→head, 16 shifts, commit both: each instance's mem matches its intended word.
   - REG_OUT=1: out lags in by exactly 1 cycle.
6. Corner events:
   - Simultaneous commit and shift in FULL: mem takes the pre-shift sr, and cnt = 1.
   - pReset after 3 shifts: cnt = 0, sr = 0, and a later commit is refused until 8 new shifts.
